dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbitrates the single data-memory port between two requesters:
  - Port A: the pipeline MEM stage, doing 16-bit loads/stores.
  - Port B: the context-save unit, doing atomic 32-bit transfers as two 16-bit beats (low half at addr, high half at addr+1). Used for interrupt/call PC and flag save/restore.
- Port A has priority. A starvation counter bounds B's wait.
- Sits between the MEM stage / context-save unit and the data memory instance. Drives the memory's read/write enables, addresses and write data.

Parameters:
ADDR_W  10  data-memory word-address width
MAX_WAIT  4  cycles B may be denied before it overrides A (1..15)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
a_req  in  1  A access request (single cycle, held by pipeline)
a_we  in  1  A write (1) / read (0)
a_addr  in  ADDR_W  A word address
a_wdata  in  16  A store data
a_gnt  out  1  A granted this cycle (combinational)
a_rvalid  out  1  A read data valid
a_rdata  out  16  A read data
b_req  in  1  B request, held until b_gnt
b_we  in  1  B write / read
b_addr  in  ADDR_W  B base address
b_wdata  in  32  B write data
b_gnt  out  1  B accepted (beat 0 issued)
b_done  out  1  one-cycle pulse, B transaction complete
b_rdata  out  32  B read data {hi,lo}
mem_read_enable  out  1  to memory
mem_write_enable  out  1  to memory
mem_read_addr  out  ADDR_W  to memory
mem_write_addr  out  ADDR_W  to memory
mem_write_data  out  16  to memory
mem_read_data  in  16  from memory, valid the cycle after read issue

Behaviour:
Reset:
- rst asserted (async) forces the following:
  - state=IDLE; wait_cnt=0.
  - a_rvalid=0, b_done=0, b_rdata=0.
  - All memory enables and grants 0.
- An in-flight B transaction is abandoned: no b_done, memory may hold beat 0 only.

States:
- IDLE: decides every cycle; at most one access issued per cycle.
  - If b_req && (!a_req || wait_cnt==MAX_WAIT):
    - b_gnt=1; issue beat 0 at b_addr.
    - Latch b_we, b_addr, b_wdata.
    - wait_cnt<=0; go to B_HI.
  - Else if a_req: a_gnt=1; issue A access this cycle.
  - Else: memory enables 0.
- B_HI: issue beat 1 at latched b_addr+1 (mod 2^ADDR_W; addr 2^ADDR_W-1 wraps to 0).
  - a_gnt=0; b_gnt=0.
  - Next state IDLE.

Memory drive:
- Write access: mem_write_enable=1, mem_write_addr=addr, mem_write_data = A data, B low half (beat 0) or B high half (beat 1). mem_read_enable=0.
- Read access: mem_read_enable=1, mem_read_addr=addr. mem_write_enable=0.
- Unused address/data outputs drive 0.

Read returns:
- A read granted in cycle t: a_rvalid=1 in t+1 (registered); a_rdata=mem_read_data in t+1, else 0.
- B read: beat 0 issued in t, beat 1 in t+1.
  - b_rdata[15:0] <= mem_read_data at end of t+1.
  - b_rdata[31:16] <= mem_read_data at end of t+2.
  - b_done=1 in cycle t+2.
- B write: b_done=1 in t+2.
- b_rdata holds until the next B read completes.

Overlap and fairness:
- The cycle in which b_done=1 is IDLE, so A may be granted in the same cycle.
- b_req is ignored from b_gnt until b_done has been asserted.
- wait_cnt increments each cycle b_req=1 and B is not granted, saturating at MAX_WAIT. It resets on b_gnt, or when b_req=0.
- When B wins with a_req=1, A simply waits (a_gnt=0). The pipeline stalls on !a_gnt.

Test Plan:
- A alone: a_req/write addr 5 data 0x1234, then read addr 5 -> a_gnt same cycle both times; a_rvalid=1 with a_rdata=0x1234 one cycle after read grant.
- B alone: write addr 8 data 0xBEEF_CAFE, then read addr 8 -> mem addr 8 gets 0xCAFE, addr 9 gets 0xBEEF; b_done 2 cycles after b_gnt; b_rdata=0xBEEFCAFE.
- Contention: a_req held high continuously, b_req raised -> B granted exactly after MAX_WAIT=4 denied cycles; a_gnt=0 for 2 cycles; A re-granted in the b_done cycle.
- Wrap: B write addr 1023 (ADDR_W=10) -> beat 1 at addr 0.
- Reset mid-op: assert rst during B_HI -> all outputs 0 immediately, no b_done; after release, A request granted at once.
- Idle: no requests for 10 cycles -> mem_read_enable=mem_write_enable=0, wait_cnt stays 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between two requesters.
//   Port A: pipeline MEM stage, single-cycle 16-bit loads/stores. Has priority.
//   Port B: context-save unit, atomic 32-bit transfers issued as two 16-bit
//           beats (low half at addr, high half at addr+1).
// A starvation counter lets B override A after MAX_WAIT denied cycles.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   A request (held by the pipeline until a_gnt)
//   a_gnt                  A issued this cycle (combinational)
//   a_rvalid/a_rdata       A read return, one cycle after the grant
//   b_req/b_we/b_addr/b_wdata   B request, held until b_gnt
//   b_gnt                  B accepted, beat 0 issued this cycle (combinational)
//   b_done                 one-cycle pulse when B completes
//   b_rdata                B read data {hi,lo}, held until the next B read
//   mem_*                  memory read/write port; read data valid next cycle

module dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [15:0]       a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [15:0]       a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [31:0]       b_rdata,
  output logic              mem_read_enable,
  output logic              mem_write_enable,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [15:0]       mem_write_data,
  input  logic [15:0]       mem_read_data
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_B_HI = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_wait_cnt;
  logic              r_b_we;
  logic [ADDR_W-1:0] r_b_addr;
  logic [31:0]       r_b_wdata;
  logic              r_a_rvalid;
  logic              r_b_done;
  logic              r_b_cap_lo;
  logic              r_b_cap_hi;
  logic [15:0]       r_b_lo;
  logic [31:0]       r_b_rdata;

  logic              w_b_req_eff;
  logic              w_wait_max;
  logic              w_idle;
  logic              w_b_win;
  logic              w_a_win;
  logic              w_b_hi;
  logic              w_acc_en;
  logic              w_acc_we;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [15:0]       w_acc_data;

  // The b_done cycle is IDLE, but a still-high b_req there belongs to the
  // transaction just finished, so it is masked until the pulse has gone.
  assign w_b_req_eff = b_req & ~r_b_done;
  assign w_wait_max  = (r_wait_cnt == 4'(MAX_WAIT));

  // Grants are masked while rst is high so nothing reaches memory during reset.
  assign w_idle  = (r_state == ST_IDLE) & ~rst;
  assign w_b_hi  = (r_state == ST_B_HI) & ~rst;
  assign w_b_win = w_idle & w_b_req_eff & (~a_req | w_wait_max);
  assign w_a_win = w_idle & a_req & ~w_b_win;

  assign a_gnt    = w_a_win;
  assign b_gnt    = w_b_win;
  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rvalid ? mem_read_data : 16'h0000;
  assign b_done   = r_b_done;
  assign b_rdata  = r_b_rdata;

  // Select the single access issued this cycle: B beat 1, B beat 0 or A.
  always_comb begin
    w_acc_en   = 1'b0;
    w_acc_we   = 1'b0;
    w_acc_addr = '0;
    w_acc_data = 16'h0000;
    if (w_b_hi) begin
      w_acc_en   = 1'b1;
      w_acc_we   = r_b_we;
      w_acc_addr = r_b_addr + ADDR_W'(1);  // wraps at the top of memory
      w_acc_data = r_b_we ? r_b_wdata[31:16] : 16'h0000;
    end else if (w_b_win) begin
      w_acc_en   = 1'b1;
      w_acc_we   = b_we;
      w_acc_addr = b_addr;
      w_acc_data = b_we ? b_wdata[15:0] : 16'h0000;
    end else if (w_a_win) begin
      w_acc_en   = 1'b1;
      w_acc_we   = a_we;
      w_acc_addr = a_addr;
      w_acc_data = a_we ? a_wdata : 16'h0000;
    end else begin
      w_acc_en   = 1'b0;
    end
  end

  // Split the selected access onto the memory's separate read/write ports.
  always_comb begin
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_read_addr    = '0;
    mem_write_addr   = '0;
    mem_write_data   = 16'h0000;
    if (w_acc_en && w_acc_we) begin
      mem_write_enable = 1'b1;
      mem_write_addr   = w_acc_addr;
      mem_write_data   = w_acc_data;
    end else if (w_acc_en) begin
      mem_read_enable  = 1'b1;
      mem_read_addr    = w_acc_addr;
    end else begin
      mem_read_enable  = 1'b0;
    end
  end

  // Arbitration state, starvation counter, B latch and read-return registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= 4'd0;
      r_b_we     <= 1'b0;
      r_b_addr   <= '0;
      r_b_wdata  <= 32'h0000_0000;
      r_a_rvalid <= 1'b0;
      r_b_done   <= 1'b0;
      r_b_cap_lo <= 1'b0;
      r_b_cap_hi <= 1'b0;
      r_b_lo     <= 16'h0000;
      r_b_rdata  <= 32'h0000_0000;
    end else begin
      r_a_rvalid <= w_a_win & ~a_we;
      r_b_done   <= w_b_hi;
      r_b_cap_lo <= w_b_win & ~b_we;
      r_b_cap_hi <= w_b_hi & ~r_b_we;

      // Low half is staged so b_rdata changes only when the whole read lands.
      if (r_b_cap_lo) begin
        r_b_lo <= mem_read_data;
      end else begin
        r_b_lo <= r_b_lo;
      end
      if (r_b_cap_hi) begin
        r_b_rdata <= {mem_read_data, r_b_lo};
      end else begin
        r_b_rdata <= r_b_rdata;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_b_win) begin
            r_b_we     <= b_we;
            r_b_addr   <= b_addr;
            r_b_wdata  <= b_wdata;
            r_wait_cnt <= 4'd0;
            r_state    <= ST_B_HI;
          end else if (w_b_req_eff) begin
            if (!w_wait_max) begin
              r_wait_cnt <= r_wait_cnt + 4'd1;
            end else begin
              r_wait_cnt <= r_wait_cnt;
            end
          end else begin
            r_wait_cnt <= 4'd0;
          end
        end
        ST_B_HI: begin
          r_wait_cnt <= 4'd0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_wait_cnt <= 4'd0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
